// File: rtl/mem_data_ctrl.sv
// Word-addressed data memory with byte-strobed writes, 1-cycle read latency and a post-reset clear.
// Optional per-byte even parity storage enabled by defining MEM_DATA_PARITY_EN.
module mem_data_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
`ifdef MEM_DATA_PARITY_EN
    input  logic            par_inject,
    output logic            rsp_perr,
`endif
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_err,
    output logic            init_done
);

    localparam int NB = DW / 8;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    logic            acc, in_rng, rd_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [NB-1:0]   mem_be;

    logic            rd_pend_q, rd_pend_d;
    logic            rd_oor_q, rd_oor_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   ram_rd_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_RUN;
        end
    end

    // Output logic
    always_comb begin
        req_ready = (state_q == S_RUN);
        init_done = (state_q == S_RUN);
    end

    // Memory port: the clear sequence owns the port while in INIT
    always_comb begin
        acc       = req_valid && req_ready && rst_n;
        in_rng    = ({1'b0, req_addr} < DEPTH_W);
        rd_en     = acc && !req_wr && in_rng;
        if (state_q == S_INIT) begin
            mem_we    = rst_n;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else begin
            mem_we    = acc && req_wr && in_rng;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
            mem_be    = req_be;
        end
        rd_pend_d = acc && !req_wr;
        rd_oor_d  = acc && !req_wr && !in_rng;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (rd_en) ram_rd_q <= mem[mem_addr];
    end

    always_comb begin
        rsp_valid_d = rd_pend_q;
        rsp_err_d   = rd_oor_q;
        rsp_data_d  = rsp_data_q;
        if (rd_pend_q) rsp_data_d = rd_oor_q ? '0 : ram_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q   <= 1'b0;
            rd_oor_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_oor_q    <= rd_oor_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

`ifdef MEM_DATA_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_rd_q;
    logic [NB-1:0] par_be, par_val, par_chk;
    logic          rsp_perr_q, rsp_perr_d;

    // Unstrobed bytes keep their stored parity; inject flips byte 0 even when it is not strobed
    always_comb begin
        par_be = mem_be;
        for (int i = 0; i < NB; i++) par_val[i] = ^mem_wdata[8*i +: 8];
        if (state_q == S_RUN && par_inject) begin
            par_be[0]  = 1'b1;
            par_val[0] = req_be[0] ? ~par_val[0] : ~par_mem[req_addr][0];
        end
        for (int i = 0; i < NB; i++) par_chk[i] = ^ram_rd_q[8*i +: 8];
        rsp_perr_d = rd_pend_q && !rd_oor_q && (par_chk != par_rd_q);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (par_be[i]) par_mem[mem_addr][i] <= par_val[i];
            end
        end
        if (rd_en) par_rd_q <= par_mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rsp_perr_q <= 1'b0;
        else        rsp_perr_q <= rsp_perr_d;
    end

    assign rsp_perr = rsp_perr_q;
`endif

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Directed bench for mem_data_ctrl: a DEPTH=256 instance plus a DEPTH=200 instance for range checks.
module tb_mem_data_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_wr, req_ready;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_data;

    logic        v1, wr1, rdy1;
    logic [7:0]  a1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic        rv1, re1, id1;
    logic [31:0] rd1;

`ifdef MEM_DATA_PARITY_EN
    logic        par_inject, rsp_perr;
    logic        par_inject1, rsp_perr1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_data_ctrl #(.DW(32), .DEPTH(256), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef MEM_DATA_PARITY_EN
        .par_inject(par_inject), .rsp_perr(rsp_perr),
`endif
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    mem_data_ctrl #(.DW(32), .DEPTH(200), .AW(8)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_ready(rdy1), .req_wr(wr1),
        .req_addr(a1), .req_wdata(wd1), .req_be(be1),
`ifdef MEM_DATA_PARITY_EN
        .par_inject(par_inject1), .rsp_perr(rsp_perr1),
`endif
        .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1),
        .init_done(id1)
    );

    task automatic do_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = 1'b0;
    endtask

    task automatic do_rd(input logic [7:0] a);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", rsp_valid); end
        if (rsp_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", rsp_data); end
        if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", rsp_err); end
        if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b want=0", init_done); end
        rst_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        total += 2;
        if (n != 256) begin bad++; $display("FAIL init_cycles got=%0d want=256", n); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL init_ready got=%b want=1", req_ready); end
        do_rd(8'h7F);
        @(posedge clk); #1;
        total += 3;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL clr_valid got=%b want=1", rsp_valid); end
        if (rsp_data !== 32'h0) begin bad++; $display("FAIL clr_data got=%h want=0", rsp_data); end
        if (rsp_err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", rsp_err); end
    endtask

    task automatic test_write_read;
        do_wr(8'h10, 32'hDEADBEEF, 4'hF);
        do_rd(8'h10);
        total += 1;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_early got=%b want=0", rsp_valid); end
        @(posedge clk); #1;
        total += 2;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b want=1", rsp_valid); end
        if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data got=%h want=deadbeef", rsp_data); end
        @(posedge clk); #1;
        total += 2;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_pulse got=%b want=0", rsp_valid); end
        if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_hold got=%h want=deadbeef", rsp_data); end
    endtask

    task automatic test_byte_enable;
        do_wr(8'h10, 32'h11223344, 4'b0101);
        do_rd(8'h10);
        @(posedge clk); #1;
        total += 1;
        if (rsp_data !== 32'hDE22BE44) begin bad++; $display("FAIL be_merge got=%h want=de22be44", rsp_data); end
        do_wr(8'h10, 32'hFFFFFFFF, 4'b0000);
        do_rd(8'h10);
        @(posedge clk); #1;
        total += 1;
        if (rsp_data !== 32'hDE22BE44) begin bad++; $display("FAIL be_zero got=%h want=de22be44", rsp_data); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) do_wr(8'(i), 32'(i + 1), 4'hF);
        req_valid = 1'b1; req_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) req_addr = 8'(i);
            else       req_valid = 1'b0;
            @(posedge clk); #1;
            if (i > 0) begin
                total += 2;
                if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b want=1", i - 1, rsp_valid); end
                if (rsp_data !== 32'(i)) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", i - 1, rsp_data, 32'(i)); end
            end
        end
        @(posedge clk); #1;
        total += 1;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", rsp_valid); end
    endtask

    task automatic test_out_of_range;
        total += 1;
        if (id1 !== 1'b1) begin bad++; $display("FAIL oor_init got=%b want=1", id1); end
        v1 = 1'b1; wr1 = 1'b1; a1 = 8'd250; wd1 = 32'hFFFFFFFF; be1 = 4'hF;
        @(posedge clk); #1;
        wr1 = 1'b0;
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        total += 3;
        if (rv1 !== 1'b1) begin bad++; $display("FAIL oor_valid got=%b want=1", rv1); end
        if (rd1 !== 32'h0) begin bad++; $display("FAIL oor_data got=%h want=0", rd1); end
        if (re1 !== 1'b1) begin bad++; $display("FAIL oor_err got=%b want=1", re1); end
        @(posedge clk); #1;
        total += 1;
        if (re1 !== 1'b0) begin bad++; $display("FAIL oor_err_idle got=%b want=0", re1); end
        v1 = 1'b1; a1 = 8'd199;
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        total += 3;
        if (rv1 !== 1'b1) begin bad++; $display("FAIL last_valid got=%b want=1", rv1); end
        if (rd1 !== 32'h0) begin bad++; $display("FAIL last_data got=%h want=0", rd1); end
        if (re1 !== 1'b0) begin bad++; $display("FAIL last_err got=%b want=0", re1); end
    endtask

    task automatic test_reset_stream;
        int n;
        logic seen;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h10;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total += 2;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rs_cancel got=%b want=0", rsp_valid); end
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rs_ready got=%b want=0", req_ready); end
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (req_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        req_valid = 1'b0;
        total += 2;
        if (n != 256) begin bad++; $display("FAIL rs_cycles got=%0d want=256", n); end
        if (seen !== 1'b0) begin bad++; $display("FAIL rs_ignored got=%b want=0", seen); end
        do_rd(8'h10);
        @(posedge clk); #1;
        total += 2;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rs_rd_valid got=%b want=1", rsp_valid); end
        if (rsp_data !== 32'h0) begin bad++; $display("FAIL rs_cleared got=%h want=0", rsp_data); end
    endtask

`ifdef MEM_DATA_PARITY_EN
    task automatic test_parity;
        par_inject = 1'b1;
        do_wr(8'h20, 32'h000000A5, 4'hF);
        par_inject = 1'b0;
        do_rd(8'h20);
        @(posedge clk); #1;
        total += 2;
        if (rsp_data !== 32'h000000A5) begin bad++; $display("FAIL par_data got=%h want=a5", rsp_data); end
        if (rsp_perr !== 1'b1) begin bad++; $display("FAIL par_inject got=%b want=1", rsp_perr); end
        do_wr(8'h20, 32'h000000A5, 4'hF);
        do_rd(8'h20);
        @(posedge clk); #1;
        total += 1;
        if (rsp_perr !== 1'b0) begin bad++; $display("FAIL par_clean got=%b want=0", rsp_perr); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        v1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0; be1 = '0;
`ifdef MEM_DATA_PARITY_EN
        par_inject = 1'b0; par_inject1 = 1'b0;
`endif
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
`ifdef MEM_DATA_PARITY_EN
        test_parity();
`endif
        test_reset_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_data_ctrl.md
Name: mem_data_ctrl

Overview:
- Parametrised data memory for the datapath.
- Reads are registered, with 1-cycle latency.
- Requests use a valid/ready handshake; writes take per-byte strobes.
- After reset, a clear state machine zeroes the whole array; out-of-range accesses are flagged.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
DEPTH, 256, number of words
AW, 8, address width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block accepts a request this cycle
req_wr  input  1  1 = write, 0 = read
req_addr  input  AW  word address
req_wdata  input  DW  write data; two's-complement value, stored as raw bits
req_be  input  DW/8  byte enables for writes; bit i covers bits [8i+7:8i]
rsp_valid  output  1  read data valid, one-cycle pulse per read
rsp_data  output  DW  read data
rsp_err  output  1  out-of-range read; qualified by rsp_valid
init_done  output  1  clear sequence complete

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=INIT, clear counter=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0.
- INIT state:
  - Each cycle, write 0 to mem[cnt], then cnt++.
  - The write with cnt==DEPTH-1 moves the state to RUN. init_done and req_ready rise at that edge.
  - Total: DEPTH cycles after the first edge with rst_n high.
  - Requests are not accepted; req_valid is ignored.
- RUN state:
  - req_ready = 1 every cycle; there is no response backpressure.
  - A request is accepted when req_valid && req_ready at a clk edge.
- Accepted write:
  - At that edge, mem[addr] byte i <= req_wdata byte i for each i where req_be[i]=1. Other bytes are unchanged.
  - No response is generated.
  - req_be=0 is a legal no-op.
- Accepted read:
  - At the next edge, rsp_valid=1 and rsp_data=mem[addr] (value before any later write).
  - rsp_err=0 for in-range addresses.
- Back-to-back accepted reads produce a response every cycle, in order.
- Read-after-write:
  - A write at edge N followed by a read of the same address accepted at edge N+1 returns the new data at edge N+2.
- Out of range (req_addr >= DEPTH; only possible when DEPTH < 2**AW):
  - Writes are dropped.
  - Reads return rsp_data=0 with rsp_err=1.
- No response cycle: rsp_valid=0 and rsp_err=0; rsp_data holds its last value.
- rst_n low in any state, including mid-INIT or mid-stream:
  - A pending response is cancelled; rsp_valid=0 at that edge.
  - The block re-enters INIT and the full clear repeats, so prior contents are lost.
- Memory is a single-port array, inferable as block RAM with a registered read port. No initialisation file is used.

Optional Feature:
- Macro: MEM_DATA_PARITY_EN.
- With the macro defined:
  - Each word stores DW/8 extra even-parity bits, one per byte, computed from the post-merge byte on write.
  - The clear sequence writes parity 0.
  - Extra input par_inject (1 bit): when high on an accepted write, the stored parity for byte 0 is inverted.
  - Extra output rsp_perr (1 bit): asserted with rsp_valid when any byte parity mismatches. Reset value 0. Always 0 for out-of-range reads.
- Without the macro: no parity storage, and par_inject/rsp_perr do not exist.

Test Plan:
- rst_n low 2 cycles, then high -> init_done and req_ready rise exactly 256 cycles later. A read of addr 0x7F then returns 0x00000000 with rsp_err=0.
- Write 0xDEADBEEF to 0x10 with be=4'b1111, then read 0x10 on the next cycle -> rsp_valid 1 cycle after the read is accepted, rsp_data=0xDEADBEEF.
- Over 0xDEADBEEF, write 0x11223344 with be=4'b0101, then read -> 0xDE22BE44. Write with be=0, then read -> still 0xDE22BE44.
- Write 0x1,0x2,0x3 to addresses 0..2, then read 0,1,2 back-to-back -> rsp_valid high 3 consecutive cycles, data 1,2,3 in order.
- DEPTH=200, AW=8: write 0xFFFFFFFF to 250, then read 250 -> rsp_data=0, rsp_err=1. Read 199 -> 0, rsp_err=0.
- Reads streaming, rst_n low for 1 cycle -> rsp_valid=0 at that edge, req_ready=0 for 256 cycles. Previously written 0x10 reads 0 afterward.
- With MEM_DATA_PARITY_EN: write 0xA5 to 0x20 with par_inject=1, then read -> rsp_perr=1. Rewrite with par_inject=0, then read -> rsp_perr=0.
